// File: rtl/execute_cycle_mc_if.sv
// Bundle of the execute-stage inputs and EX/MEM outputs for execute_cycle_mc.
// master = pipeline side driving the E stage; slave = the execute block.
interface execute_cycle_mc_if #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
);
  logic               RegwriteE;
  logic               MemwriteE;
  logic               ALUSrcE;
  logic               JumpE;
  logic               branchE;
  logic [1:0]         ResultSrcE;
  logic [3:0]         ALUControlE;
  logic [2:0]         funct3E;
  logic [1:0]         ForwardA_E;
  logic [1:0]         ForwardB_E;
  logic [RADDR_W-1:0] RdE;
  logic [DATA_W-1:0]  RD1E;
  logic [DATA_W-1:0]  RD2E;
  logic [DATA_W-1:0]  PCE;
  logic [DATA_W-1:0]  immExtE;
  logic [DATA_W-1:0]  pc_plus4E;
  logic [DATA_W-1:0]  ResultW;
  logic               flush_i;
  logic               hold_i;

  logic               PCSrcE;
  logic [DATA_W-1:0]  PC_TargetE;
  logic               stall_o;
  logic               RegwriteM;
  logic               MemwriteM;
  logic [1:0]         ResultSrcM;
  logic [RADDR_W-1:0] RdM;
  logic [DATA_W-1:0]  ALUResultM;
  logic [DATA_W-1:0]  WriteDataM;
  logic [DATA_W-1:0]  pc_plus4M;

  modport master (
    output RegwriteE, MemwriteE, ALUSrcE, JumpE, branchE, ResultSrcE,
           ALUControlE, funct3E, ForwardA_E, ForwardB_E, RdE, RD1E, RD2E,
           PCE, immExtE, pc_plus4E, ResultW, flush_i, hold_i,
    input  PCSrcE, PC_TargetE, stall_o, RegwriteM, MemwriteM, ResultSrcM,
           RdM, ALUResultM, WriteDataM, pc_plus4M
  );

  modport slave (
    input  RegwriteE, MemwriteE, ALUSrcE, JumpE, branchE, ResultSrcE,
           ALUControlE, funct3E, ForwardA_E, ForwardB_E, RdE, RD1E, RD2E,
           PCE, immExtE, pc_plus4E, ResultW, flush_i, hold_i,
    output PCSrcE, PC_TargetE, stall_o, RegwriteM, MemwriteM, ResultSrcM,
           RdM, ALUResultM, WriteDataM, pc_plus4M
  );
endinterface

// File: rtl/execute_cycle_mc.sv
// Execute stage with forwarding, single-cycle ALU, branch resolution, a
// multicycle multiplier (IDLE/BUSY FSM) and the EX/MEM pipeline register.
module execute_cycle_mc #(
  parameter int DATA_W     = 16,
  parameter int RADDR_W    = 3,
  parameter int MUL_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  execute_cycle_mc_if.slave bus
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic {IDLE, BUSY} state_t;

  // Registered state
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mul_a_q, mul_a_d;
  logic [DATA_W-1:0]  mul_b_q, mul_b_d;
  logic               cap_regwrite_q, cap_regwrite_d;
  logic               cap_memwrite_q, cap_memwrite_d;
  logic [1:0]         cap_resultsrc_q, cap_resultsrc_d;
  logic [RADDR_W-1:0] cap_rd_q, cap_rd_d;
  logic [DATA_W-1:0]  cap_wd_q, cap_wd_d;
  logic [DATA_W-1:0]  cap_pcp4_q, cap_pcp4_d;
  logic               m_regwrite_q, m_regwrite_d;
  logic               m_memwrite_q, m_memwrite_d;
  logic [1:0]         m_resultsrc_q, m_resultsrc_d;
  logic [RADDR_W-1:0] m_rd_q, m_rd_d;
  logic [DATA_W-1:0]  m_alu_q, m_alu_d;
  logic [DATA_W-1:0]  m_wd_q, m_wd_d;
  logic [DATA_W-1:0]  m_pcp4_q, m_pcp4_d;

  // Combinational datapath
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] product;
  logic              zero;
  logic              lt_signed;
  logic              branch_taken;
  logic              is_mul;
  logic              issue;
  logic              busy;

  // Forwarding muxes; ALUResultM feeds back from our own EX/MEM register
  always_comb begin
    case (bus.ForwardA_E)
      2'b01:   fwd_a = bus.ResultW;
      2'b10:   fwd_a = m_alu_q;
      default: fwd_a = bus.RD1E;
    endcase
    case (bus.ForwardB_E)
      2'b01:   fwd_b = bus.ResultW;
      2'b10:   fwd_b = m_alu_q;
      default: fwd_b = bus.RD2E;
    endcase
  end

  assign src_a = fwd_a;
  assign src_b = bus.ALUSrcE ? bus.immExtE : fwd_b;

  // Single-cycle ALU; the MUL code yields 0 here, its result comes from the FSM
  always_comb begin
    case (bus.ALUControlE)
      OP_ADD:  alu_result = src_a + src_b;
      OP_SUB:  alu_result = src_a - src_b;
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_SLL:  alu_result = src_a << src_b[SH_W-1:0];
      OP_SRL:  alu_result = src_a >> src_b[SH_W-1:0];
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, lt_signed};
      default: alu_result = '0;
    endcase
  end

  assign lt_signed = $signed(src_a) < $signed(src_b);
  assign zero      = (alu_result == '0);
  assign product   = mul_a_q * mul_b_q;

  // Branch condition decode from funct3
  always_comb begin
    case (bus.funct3E)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = lt_signed;
      default: branch_taken = 1'b0;
    endcase
  end

  assign busy   = (state_q == BUSY);
  assign is_mul = (bus.ALUControlE == OP_MUL);
  assign issue  = (state_q == IDLE) && is_mul && !bus.flush_i && !bus.hold_i;

  assign bus.PCSrcE     = (bus.JumpE | (bus.branchE & branch_taken)) & !bus.flush_i & !busy;
  assign bus.PC_TargetE = bus.PCE + bus.immExtE;
  assign bus.stall_o    = issue | (busy && (cnt_q != '0)) | bus.hold_i;

  // Next-state: flush > hold > multiply > normal; rst is applied in the flop block
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mul_a_d         = mul_a_q;
    mul_b_d         = mul_b_q;
    cap_regwrite_d  = cap_regwrite_q;
    cap_memwrite_d  = cap_memwrite_q;
    cap_resultsrc_d = cap_resultsrc_q;
    cap_rd_d        = cap_rd_q;
    cap_wd_d        = cap_wd_q;
    cap_pcp4_d      = cap_pcp4_q;
    m_regwrite_d    = m_regwrite_q;
    m_memwrite_d    = m_memwrite_q;
    m_resultsrc_d   = m_resultsrc_q;
    m_rd_d          = m_rd_q;
    m_alu_d         = m_alu_q;
    m_wd_d          = m_wd_q;
    m_pcp4_d        = m_pcp4_q;

    if (bus.flush_i) begin
      state_d       = IDLE;
      cnt_d         = '0;
      m_regwrite_d  = 1'b0;
      m_memwrite_d  = 1'b0;
      m_resultsrc_d = '0;
      m_rd_d        = '0;
      m_alu_d       = '0;
      m_wd_d        = '0;
      m_pcp4_d      = '0;
    end else if (bus.hold_i) begin
      state_d = state_q;
    end else if (busy) begin
      if (cnt_q == '0) begin
        state_d       = IDLE;
        m_regwrite_d  = cap_regwrite_q;
        m_memwrite_d  = cap_memwrite_q;
        m_resultsrc_d = cap_resultsrc_q;
        m_rd_d        = cap_rd_q;
        m_alu_d       = product;
        m_wd_d        = cap_wd_q;
        m_pcp4_d      = cap_pcp4_q;
      end else begin
        cnt_d         = cnt_q - 1'b1;
        m_regwrite_d  = 1'b0;
        m_memwrite_d  = 1'b0;
        m_resultsrc_d = '0;
        m_rd_d        = '0;
        m_alu_d       = '0;
        m_wd_d        = '0;
        m_pcp4_d      = '0;
      end
    end else if (is_mul) begin
      state_d         = BUSY;
      cnt_d           = CNT_LOAD;
      mul_a_d         = src_a;
      mul_b_d         = src_b;
      cap_regwrite_d  = bus.RegwriteE;
      cap_memwrite_d  = bus.MemwriteE;
      cap_resultsrc_d = bus.ResultSrcE;
      cap_rd_d        = bus.RdE;
      cap_wd_d        = fwd_b;
      cap_pcp4_d      = bus.pc_plus4E;
      m_regwrite_d    = 1'b0;
      m_memwrite_d    = 1'b0;
      m_resultsrc_d   = '0;
      m_rd_d          = '0;
      m_alu_d         = '0;
      m_wd_d          = '0;
      m_pcp4_d        = '0;
    end else begin
      m_regwrite_d  = bus.RegwriteE;
      m_memwrite_d  = bus.MemwriteE;
      m_resultsrc_d = bus.ResultSrcE;
      m_rd_d        = bus.RdE;
      m_alu_d       = alu_result;
      m_wd_d        = fwd_b;
      m_pcp4_d      = bus.pc_plus4E;
    end
  end

  // State, multiply capture and EX/MEM registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      mul_a_q         <= '0;
      mul_b_q         <= '0;
      cap_regwrite_q  <= 1'b0;
      cap_memwrite_q  <= 1'b0;
      cap_resultsrc_q <= '0;
      cap_rd_q        <= '0;
      cap_wd_q        <= '0;
      cap_pcp4_q      <= '0;
      m_regwrite_q    <= 1'b0;
      m_memwrite_q    <= 1'b0;
      m_resultsrc_q   <= '0;
      m_rd_q          <= '0;
      m_alu_q         <= '0;
      m_wd_q          <= '0;
      m_pcp4_q        <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mul_a_q         <= mul_a_d;
      mul_b_q         <= mul_b_d;
      cap_regwrite_q  <= cap_regwrite_d;
      cap_memwrite_q  <= cap_memwrite_d;
      cap_resultsrc_q <= cap_resultsrc_d;
      cap_rd_q        <= cap_rd_d;
      cap_wd_q        <= cap_wd_d;
      cap_pcp4_q      <= cap_pcp4_d;
      m_regwrite_q    <= m_regwrite_d;
      m_memwrite_q    <= m_memwrite_d;
      m_resultsrc_q   <= m_resultsrc_d;
      m_rd_q          <= m_rd_d;
      m_alu_q         <= m_alu_d;
      m_wd_q          <= m_wd_d;
      m_pcp4_q        <= m_pcp4_d;
    end
  end

  assign bus.RegwriteM  = m_regwrite_q;
  assign bus.MemwriteM  = m_memwrite_q;
  assign bus.ResultSrcM = m_resultsrc_q;
  assign bus.RdM        = m_rd_q;
  assign bus.ALUResultM = m_alu_q;
  assign bus.WriteDataM = m_wd_q;
  assign bus.pc_plus4M  = m_pcp4_q;

endmodule

// File: tb/tb_execute_cycle_mc.sv
// Directed scoreboard bench for execute_cycle_mc (DATA_W=16, RADDR_W=3, MUL_CYCLES=4).
module tb_execute_cycle_mc;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic        alusrc;
    logic        jump;
    logic        branch;
    logic [1:0]  resultsrc;
    logic [3:0]  aluctl;
    logic [2:0]  funct3;
    logic [1:0]  fwda;
    logic [1:0]  fwdb;
    logic [2:0]  rd;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] pce;
    logic [15:0] imm;
    logic [15:0] pcp4;
    logic [15:0] resultw;
    logic        flush;
    logic        hold;
  } instr_t;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  resultsrc;
    logic [2:0]  rd;
    logic [15:0] alu;
    logic [15:0] wd;
    logic [15:0] pcp4;
  } wb_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  wb_t  sb[$];

  execute_cycle_mc_if #(.DATA_W(16), .RADDR_W(3)) bus();

  execute_cycle_mc #(.DATA_W(16), .RADDR_W(3), .MUL_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic instr_t nopInstr();
    instr_t i;
    i = '0;
    return i;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input instr_t i);
    bus.RegwriteE   = i.regwrite;
    bus.MemwriteE   = i.memwrite;
    bus.ALUSrcE     = i.alusrc;
    bus.JumpE       = i.jump;
    bus.branchE     = i.branch;
    bus.ResultSrcE  = i.resultsrc;
    bus.ALUControlE = i.aluctl;
    bus.funct3E     = i.funct3;
    bus.ForwardA_E  = i.fwda;
    bus.ForwardB_E  = i.fwdb;
    bus.RdE         = i.rd;
    bus.RD1E        = i.rd1;
    bus.RD2E        = i.rd2;
    bus.PCE         = i.pce;
    bus.immExtE     = i.imm;
    bus.pc_plus4E   = i.pcp4;
    bus.ResultW     = i.resultw;
    bus.flush_i     = i.flush;
    bus.hold_i      = i.hold;
  endtask

  task automatic expectWb(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] rd,
                          input logic [15:0] alu, input logic [15:0] wd, input logic [15:0] pcp4);
    wb_t e;
    e.regwrite  = rw;
    e.memwrite  = mw;
    e.resultsrc = rs;
    e.rd        = rd;
    e.alu       = alu;
    e.wd        = wd;
    e.pcp4      = pcp4;
    sb.push_back(e);
  endtask

  // Issue one instruction for a single cycle
  task automatic issueOne(input instr_t i);
    @(negedge clk);
    applyStimulus(i);
    #1;
  endtask

  // Drive a MUL and keep it in E while stall_o is high; disturbs the forwarded
  // operands and JumpE during BUSY, optionally holds for 2 cycles at holdAt
  task automatic runMul(input instr_t mulInstr, input int holdAt, output int stalls);
    instr_t cur;
    cur = mulInstr;
    @(negedge clk);
    applyStimulus(cur);
    #1;
    stalls = 0;
    while (bus.stall_o === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
      if (stalls == 1) begin
        cur.rd1     = cur.rd1 ^ 16'h00F0;
        cur.resultw = cur.resultw ^ 16'h0F00;
        cur.jump    = 1'b1;
      end
      if (holdAt >= 0 && stalls == holdAt) cur.hold = 1'b1;
      if (holdAt >= 0 && stalls == holdAt + 2) cur.hold = 1'b0;
      applyStimulus(cur);
      #1;
      checkOutput("mul_busy_pcsrc", {31'd0, bus.PCSrcE}, 32'd0);
    end
  endtask

  // Monitor: every real writeback on EX/MEM is matched against the scoreboard
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (bus.RegwriteM === 1'b1 || bus.MemwriteM === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL wb_unexpected actual=alu %h rd %0d required=no writeback", bus.ALUResultM, bus.RdM);
        end else begin
          e = sb.pop_front();
          checkOutput("wb_regwrite", {31'd0, bus.RegwriteM}, {31'd0, e.regwrite});
          checkOutput("wb_memwrite", {31'd0, bus.MemwriteM}, {31'd0, e.memwrite});
          checkOutput("wb_resultsrc", {30'd0, bus.ResultSrcM}, {30'd0, e.resultsrc});
          checkOutput("wb_rd", {29'd0, bus.RdM}, {29'd0, e.rd});
          checkOutput("wb_alu", {16'd0, bus.ALUResultM}, {16'd0, e.alu});
          checkOutput("wb_writedata", {16'd0, bus.WriteDataM}, {16'd0, e.wd});
          checkOutput("wb_pcplus4", {16'd0, bus.pc_plus4M}, {16'd0, e.pcp4});
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    instr_t i;
    int n;
    errors = 0;
    checks = 0;

    // Reset with a live ADD on the inputs: nothing may reach EX/MEM
    rst = 1'b1;
    i = nopInstr();
    i.regwrite = 1'b1; i.rd = 3'd6; i.rd1 = 16'h1111; i.rd2 = 16'h2222; i.pcp4 = 16'h0ABC;
    applyStimulus(i);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_regwrite", {31'd0, bus.RegwriteM}, 32'd0);
    checkOutput("rst_memwrite", {31'd0, bus.MemwriteM}, 32'd0);
    checkOutput("rst_resultsrc", {30'd0, bus.ResultSrcM}, 32'd0);
    checkOutput("rst_rd", {29'd0, bus.RdM}, 32'd0);
    checkOutput("rst_alu", {16'd0, bus.ALUResultM}, 32'd0);
    checkOutput("rst_writedata", {16'd0, bus.WriteDataM}, 32'd0);
    checkOutput("rst_pcplus4", {16'd0, bus.pc_plus4M}, 32'd0);
    checkOutput("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    rst = 1'b0;
    applyStimulus(nopInstr());

    // ADD with immediate wraps: 5 + 0xFFFF = 4
    i = nopInstr();
    i.regwrite = 1'b1; i.alusrc = 1'b1; i.rd = 3'd3; i.rd1 = 16'h0005; i.imm = 16'hFFFF;
    i.rd2 = 16'h1111; i.pcp4 = 16'h0024;
    expectWb(1'b1, 1'b0, 2'b00, 3'd3, 16'h0004, 16'h1111, 16'h0024);
    issueOne(i);

    // SUB with B forwarded from ResultW; write data takes the forwarded value
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b0001; i.resultsrc = 2'b01; i.fwdb = 2'b01; i.rd = 3'd5;
    i.rd1 = 16'h0010; i.rd2 = 16'h7777; i.resultw = 16'h0003; i.pcp4 = 16'h0028;
    expectWb(1'b1, 1'b0, 2'b01, 3'd5, 16'h000D, 16'h0003, 16'h0028);
    issueOne(i);

    // OR producing 0x00AA, then AND forwarding it from ALUResultM
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b0011; i.alusrc = 1'b1; i.rd = 3'd1;
    i.rd1 = 16'h00A0; i.imm = 16'h000A; i.pcp4 = 16'h002C;
    expectWb(1'b1, 1'b0, 2'b00, 3'd1, 16'h00AA, 16'h0000, 16'h002C);
    issueOne(i);
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b0010; i.alusrc = 1'b1; i.fwda = 2'b10; i.fwdb = 2'b10; i.rd = 3'd2;
    i.rd1 = 16'h0000; i.imm = 16'h00F0; i.rd2 = 16'h0BAD; i.pcp4 = 16'h0030;
    expectWb(1'b1, 1'b0, 2'b00, 3'd2, 16'h00A0, 16'h00AA, 16'h0030);
    issueOne(i);

    // Store with XOR address
    i = nopInstr();
    i.memwrite = 1'b1; i.aluctl = 4'b0100; i.rd1 = 16'hFF00; i.rd2 = 16'h0FF0; i.pcp4 = 16'h0034;
    expectWb(1'b0, 1'b1, 2'b00, 3'd0, 16'hF0F0, 16'h0FF0, 16'h0034);
    issueOne(i);

    // Shifts use only the low 4 bits of SrcB
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b0101; i.alusrc = 1'b1; i.rd = 3'd4;
    i.rd1 = 16'h0003; i.imm = 16'h0014; i.pcp4 = 16'h0038;
    expectWb(1'b1, 1'b0, 2'b00, 3'd4, 16'h0030, 16'h0000, 16'h0038);
    issueOne(i);
    i.aluctl = 4'b0110; i.rd1 = 16'h8000; i.imm = 16'h000F; i.pcp4 = 16'h003C;
    expectWb(1'b1, 1'b0, 2'b00, 3'd4, 16'h0001, 16'h0000, 16'h003C);
    issueOne(i);

    // Signed SLT both ways
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b0111; i.rd = 3'd6; i.rd1 = 16'hFFFE; i.rd2 = 16'h0001; i.pcp4 = 16'h0040;
    expectWb(1'b1, 1'b0, 2'b00, 3'd6, 16'h0001, 16'h0001, 16'h0040);
    issueOne(i);
    i.rd1 = 16'h0001; i.rd2 = 16'hFFFE; i.pcp4 = 16'h0042;
    expectWb(1'b1, 1'b0, 2'b00, 3'd6, 16'h0000, 16'hFFFE, 16'h0042);
    issueOne(i);

    // Unused ALU code gives 0
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b1001; i.rd = 3'd7; i.rd1 = 16'h0005; i.rd2 = 16'h0003; i.pcp4 = 16'h0044;
    expectWb(1'b1, 1'b0, 2'b00, 3'd7, 16'h0000, 16'h0003, 16'h0044);
    issueOne(i);

    // Branch resolution and target
    i = nopInstr();
    i.branch = 1'b1; i.aluctl = 4'b0001; i.funct3 = 3'b001; i.rd1 = 16'h1234; i.rd2 = 16'h1234;
    i.pce = 16'h0010; i.imm = 16'hFFF8;
    issueOne(i);
    checkOutput("bne_equal", {31'd0, bus.PCSrcE}, 32'd0);
    checkOutput("pc_target", {16'd0, bus.PC_TargetE}, 32'h0008);
    i.rd2 = 16'h1235;
    issueOne(i);
    checkOutput("bne_differ", {31'd0, bus.PCSrcE}, 32'd1);
    i.funct3 = 3'b000; i.rd2 = 16'h1234;
    issueOne(i);
    checkOutput("beq_equal", {31'd0, bus.PCSrcE}, 32'd1);
    i.funct3 = 3'b100; i.rd1 = 16'hFFFF; i.rd2 = 16'h0001;
    issueOne(i);
    checkOutput("blt_taken", {31'd0, bus.PCSrcE}, 32'd1);
    i.rd1 = 16'h0001; i.rd2 = 16'hFFFF;
    issueOne(i);
    checkOutput("blt_not_taken", {31'd0, bus.PCSrcE}, 32'd0);
    i.funct3 = 3'b010; i.rd1 = 16'h1234; i.rd2 = 16'h1234;
    issueOne(i);
    checkOutput("funct3_other", {31'd0, bus.PCSrcE}, 32'd0);
    i = nopInstr();
    i.jump = 1'b1;
    issueOne(i);
    checkOutput("jump_taken", {31'd0, bus.PCSrcE}, 32'd1);
    i.flush = 1'b1;
    issueOne(i);
    checkOutput("jump_flushed", {31'd0, bus.PCSrcE}, 32'd0);

    // MUL 3*7: four stall cycles, product on the fifth edge
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b1000; i.rd = 3'd2; i.rd1 = 16'h0003; i.rd2 = 16'h0007; i.pcp4 = 16'h0048;
    expectWb(1'b1, 1'b0, 2'b00, 3'd2, 16'h0015, 16'h0007, 16'h0048);
    runMul(i, -1, n);
    checkOutput("mul_stall_cycles", n, 32'd4);
    checkOutput("mul_no_early_wb", {31'd0, bus.RegwriteM}, 32'd0);
    issueOne(nopInstr());
    checkOutput("mul_result", {16'd0, bus.ALUResultM}, 32'h0015);
    checkOutput("mul_regwrite", {31'd0, bus.RegwriteM}, 32'd1);

    // MUL with A forwarded from ResultW, product wraps to the low 16 bits
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b1000; i.fwda = 2'b01; i.rd = 3'd5;
    i.rd1 = 16'hDEAD; i.resultw = 16'h0101; i.rd2 = 16'h0101; i.pcp4 = 16'h0060;
    expectWb(1'b1, 1'b0, 2'b00, 3'd5, 16'h0201, 16'h0101, 16'h0060);
    runMul(i, -1, n);
    checkOutput("mulfwd_stall_cycles", n, 32'd4);
    issueOne(nopInstr());
    checkOutput("mulfwd_result", {16'd0, bus.ALUResultM}, 32'h0201);

    // Flush in the second MUL cycle aborts it
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b1000; i.rd = 3'd1; i.rd1 = 16'h0004; i.rd2 = 16'h0005;
    issueOne(i);
    checkOutput("flush_issue_stall", {31'd0, bus.stall_o}, 32'd1);
    i.flush = 1'b1;
    issueOne(i);
    issueOne(nopInstr());
    checkOutput("flush_stall_after", {31'd0, bus.stall_o}, 32'd0);
    checkOutput("flush_no_wb", {31'd0, bus.RegwriteM}, 32'd0);
    repeat (5) issueOne(nopInstr());

    // Two hold cycles mid-MUL delay completion by two
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b1000; i.rd = 3'd3; i.rd1 = 16'h0006; i.rd2 = 16'h0005; i.pcp4 = 16'h0050;
    expectWb(1'b1, 1'b0, 2'b00, 3'd3, 16'h001E, 16'h0005, 16'h0050);
    runMul(i, 2, n);
    checkOutput("hold_stall_cycles", n, 32'd6);
    issueOne(nopInstr());
    checkOutput("hold_mul_result", {16'd0, bus.ALUResultM}, 32'h001E);

    // Reset mid-MUL
    i = nopInstr();
    i.regwrite = 1'b1; i.aluctl = 4'b1000; i.rd = 3'd4; i.rd1 = 16'h0002; i.rd2 = 16'h0003; i.pcp4 = 16'h0054;
    issueOne(i);
    issueOne(i);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(nopInstr());
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstmul_stall", {31'd0, bus.stall_o}, 32'd0);
    checkOutput("rstmul_regwrite", {31'd0, bus.RegwriteM}, 32'd0);
    checkOutput("rstmul_pcplus4", {16'd0, bus.pc_plus4M}, 32'd0);
    repeat (5) issueOne(nopInstr());

    // Normal single-cycle operation resumes after reset
    i = nopInstr();
    i.regwrite = 1'b1; i.alusrc = 1'b1; i.rd = 3'd1; i.rd1 = 16'h0100; i.imm = 16'h0023; i.pcp4 = 16'h0058;
    expectWb(1'b1, 1'b0, 2'b00, 3'd1, 16'h0123, 16'h0000, 16'h0058);
    issueOne(i);
    issueOne(nopInstr());
    checkOutput("post_rst_add", {16'd0, bus.ALUResultM}, 32'h0123);

    repeat (4) issueOne(nopInstr());
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_cycle_mc.md
EXECUTE_CYCLE_MC -- requirements
Module: execute_cycle_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16: datapath, PC and immediate width.
REQ-002 SHALL have parameter RADDR_W, default 3: register-address width.
REQ-003 SHALL have parameter MUL_CYCLES, default 4, legal range 2..16: multiply latency.
REQ-004 SHALL use one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-005 SHALL have the following ports, as name / direction / width / meaning:
- clk / in / 1 / clock, rising edge.
- rst / in / 1 / synchronous reset, active-high.
- RegwriteE, MemwriteE, ALUSrcE, JumpE, branchE / in / 1 each / decoded controls.
- ResultSrcE / in / 2 / result select.
- ALUControlE / in / 4 / ALU operation.
- funct3E / in / 3 / branch condition.
- ForwardA_E, ForwardB_E / in / 2 each / forwarding select: 00 = RD*E, 01 = ResultW, 10 = ALUResultM, 11 = RD*E.
- RdE / in / RADDR_W / destination register.
- RD1E, RD2E, PCE, immExtE, pc_plus4E, ResultW / in / DATA_W each / operands.
- flush_i / in / 1 / kill the instruction in E.
- hold_i / in / 1 / downstream freeze.
- PCSrcE / out / 1 / redirect taken.
- PC_TargetE / out / DATA_W / PCE + immExtE, modulo 2^DATA_W.
- stall_o / out / 1 / freeze the fetch, decode and E input registers.
- RegwriteM, MemwriteM / out / 1 each.
- ResultSrcM / out / 2.
- RdM / out / RADDR_W.
- ALUResultM, WriteDataM, pc_plus4M / out / DATA_W each.

Function
REQ-006 SrcA SHALL be the forwarded RD1E. SrcB SHALL be immExtE when ALUSrcE=1, otherwise the forwarded RD2E.
REQ-007 WriteDataE SHALL be the forwarded RD2E, never the raw RD2E.
REQ-008 The ALU SHALL implement these ALUControlE encodings:
- 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
- 0101 SLL and 0110 SRL, shift amount = SrcB[log2(DATA_W)-1:0].
- 0111 SLT, signed, result 1 or 0.
- 1000 MUL, multicycle, low DATA_W bits of the product.
- All other codes produce 0.
- Arithmetic wraps modulo 2^DATA_W.
REQ-009 Zero SHALL be asserted when the single-cycle ALU result equals 0.
REQ-010 PCSrcE SHALL be combinational and equal:
- JumpE, or
- branchE with funct3E 000 (BEQ: Zero), 001 (BNE: !Zero) or 100 (BLT: signed SrcA<SrcB).
- Other funct3E values give 0.
REQ-011 PCSrcE SHALL be forced to 0 when flush_i=1 or the multiply FSM is BUSY.
REQ-012 The multiply FSM SHALL have states IDLE and BUSY, with a counter of ceil(log2(MUL_CYCLES)) bits.
REQ-013 Issue: in IDLE with ALUControlE=1000, flush_i=0 and hold_i=0, the block SHALL capture SrcA/SrcB and all E controls, load the counter with MUL_CYCLES-1, and enter BUSY.
REQ-014 In BUSY the counter SHALL decrement each non-held cycle. When the counter is 0, the product SHALL be valid, the EX/MEM register SHALL load the captured controls plus the product, and the FSM SHALL return to IDLE.
REQ-015 stall_o SHALL equal issue | (BUSY & counter!=0) | hold_i, giving exactly MUL_CYCLES stall cycles per multiply when hold_i=0.
REQ-016 While stall_o=1 because of the multiply, the EX/MEM register SHALL load a bubble (RegwriteM=0, MemwriteM=0, other fields don't-care-but-deterministic 0).
REQ-017 Forwarded operand changes during BUSY SHALL NOT affect the product.
REQ-018 hold_i=1 SHALL freeze the EX/MEM register, the FSM state and the counter.
REQ-019 flush_i=1 SHALL load a bubble into EX/MEM and force the FSM to IDLE, aborting any multiply.
REQ-020 Priority SHALL be rst > flush_i > hold_i > multiply > normal.
REQ-021 For non-MUL operations, EX/MEM SHALL load all E values at the next edge with 1-cycle latency.

Reset
REQ-022 When rst=1 at a rising edge, the block SHALL clear RegwriteM, MemwriteM, ResultSrcM, RdM, ALUResultM, WriteDataM and pc_plus4M to 0, and set the FSM to IDLE and the counter to 0.
REQ-023 During reset, outputs SHALL NOT be combinationally masked by rst; they SHALL reflect register contents only.
REQ-024 Reset asserted mid-multiply SHALL abort it, and stall_o SHALL be 0 in the cycle after reset unless a new MUL is presented.

Verification
REQ-025 ADD with RD1E=0x0005, ALUSrcE=1, immExtE=0xFFFF, RegwriteE=1, RdE=3 -> next edge: ALUResultM=0x0004, RegwriteM=1, RdM=3.
REQ-026 BNE with SrcA=SrcB=0x1234 -> PCSrcE=0. With SrcB=0x1235 -> PCSrcE=1. With PCE=0x0010, immExtE=0xFFF8 -> PC_TargetE=0x0008.
REQ-027 ForwardA_E=10, ALUResultM=0x00AA, RD1E=0x0000, AND with SrcB=0x00F0 -> ALUResultM=0x00A0 next edge.
REQ-028 MUL 0x0003*0x0007 with MUL_CYCLES=4 -> stall_o high for 4 cycles, RegwriteM=0 during them, ALUResultM=0x0015 with RegwriteM=1 at the 5th edge. Changing RD1E during BUSY has no effect.
REQ-029 flush_i pulsed in the 2nd cycle of a MUL -> FSM IDLE, stall_o=0 next cycle, no writeback of the product.
REQ-030 hold_i held 2 cycles mid-MUL -> completion delayed exactly 2 cycles. rst mid-MUL -> all M outputs 0 and stall_o=0 next cycle.
